webp_mb_sequencer: RTL and testbench
====================================

WEBP_MB_SEQUENCER -- requirements
Module: webp_mb_sequencer

Interface
REQ-001 Parameter DATA_W, default 1024: width of one output FIFO beat.
REQ-002 Parameter NUM_BEATS, default 7: beats per macroblock result, range 1..15.
REQ-003 Parameter COORD_W, default 10: width of x, y, w1, h1.
REQ-004 Parameter BND_W, default 568: width of the opaque boundary-context bundle.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle frame start, sampled only in IDLE.
REQ-008 abort  in  1  frame abort, effective in any state.
REQ-009 w1, h1  in  COORD_W each  last macroblock column and row index.
REQ-010 bnd_init  in  BND_W  boundary context loaded at frame start.
REQ-011 in_empty  in  1  input pixel FIFO empty.
REQ-012 in_rd  out  1  input FIFO pop, one cycle per macroblock.
REQ-013 eng_start  out  1  one-cycle engine start pulse.
REQ-014 eng_done  in  1  one-cycle engine completion pulse.
REQ-015 eng_result  in  NUM_BEATS*DATA_W  engine result, valid in the eng_done cycle; beat k is bits [k*DATA_W +: DATA_W].
REQ-016 bnd_next  in  BND_W  updated boundary from the boundary-save logic, valid from eng_done onward.
REQ-017 x, y  out  COORD_W each  current macroblock coordinates.
REQ-018 bnd_q  out  BND_W  registered boundary context driven to the engine.
REQ-019 out_full  in  1  output FIFO full.
REQ-020 out_wr, out_data  out  1, DATA_W  output FIFO write strobe and data.
REQ-021 busy, done  out  1 each  frame in progress; one-cycle frame-complete pulse.

Function
REQ-022 States: IDLE, INIT, WAIT_IN, START, BUSY, DRAIN, ADVANCE, DONE.
REQ-023 Transitions:
  - IDLE to INIT on start.
  - INIT loads x=0, y=0, bnd_q=bnd_init, then goes to WAIT_IN.
  - WAIT_IN stays while in_empty; otherwise asserts in_rd for one cycle and goes to START.
  - START asserts eng_start for one cycle, then goes to BUSY.
  - BUSY waits for eng_done.
  - DRAIN emits beats.
  - ADVANCE updates state.
  - DONE pulses done, then goes to IDLE.
REQ-024 On eng_done in BUSY:
  - eng_result is captured into an internal buffer and bnd_next into a shadow register in the same cycle.
  - Next state is DRAIN.
REQ-025 DRAIN write rules:
  - out_wr=1 only in cycles where out_full=0, with out_data = buffer beat given by the beat counter.
  - The beat counter increments only on a write.
  - When out_full=1, out_wr=0 and out_data holds its value.
REQ-026 DRAIN exit: after beat NUM_BEATS-1 is written, go to DONE if x==w1 and y==h1, else go to ADVANCE.
REQ-027 ADVANCE update, in one cycle:
  - bnd_q loads the shadow register.
  - If x==w1, then x=0 and y=y+1; otherwise x=x+1.
  - Next state is WAIT_IN.
REQ-028 Exactly one in_rd, one eng_start and NUM_BEATS out_wr per macroblock.
REQ-029 Frame totals are (w1+1)*(h1+1) macroblocks and (w1+1)*(h1+1)*NUM_BEATS writes.
REQ-030 eng_done outside BUSY is ignored; start outside IDLE is ignored.
REQ-031 abort has priority over all transitions: next state IDLE, out_wr=0, no done pulse, and x, y, bnd_q retain their values.
REQ-032 busy=1 in every state except IDLE.
REQ-033 w1=0 and h1=0 is legal: a single-macroblock frame.
REQ-034 Minimum per-macroblock overhead with no stalls:
  - Cycles outside BUSY and DRAIN: WAIT_IN, START, ADVANCE = 3.
  - DRAIN takes NUM_BEATS cycles.

Reset
REQ-035 Asynchronous reset puts the state in IDLE and clears all registers to 0: x, y, bnd_q, buffer, beat counter.
REQ-036 During reset, outputs in_rd, eng_start, out_wr, out_data, busy and done shall all be 0.

Configuration
REQ-037 Macro WEBP_MB_SEQ_PERF_EN, when defined, adds three 32-bit saturating counters:
  - perf_in_stall: cycles in WAIT_IN with in_empty=1.
  - perf_out_stall: cycles in DRAIN with out_full=1.
  - perf_eng_busy: cycles in BUSY.
  - The counters clear in INIT and are held at 0 on reset.
REQ-038 Without WEBP_MB_SEQ_PERF_EN:
  - The perf ports and counters are absent.
  - All other behaviour is identical.

Structure
REQ-039 The shared package holds:
  - the state enumeration,
  - the default boundary width constant 568,
  - the default DATA_W and NUM_BEATS.
REQ-040 One sub-module, webp_beat_serializer, holds the result buffer, beat counter and the out_full-gated write logic.

Verification
REQ-041 w1=1, h1=1, NUM_BEATS=7, FIFOs never stall, engine done 20 cycles after eng_start:
  - 4 in_rd and 4 eng_start.
  - 28 out_wr in beat order 0..6.
  - (x,y) sequence (0,0),(1,0),(0,1),(1,1).
  - One done pulse.
REQ-042 out_full held high for 5 cycles during beat 3:
  - out_wr=0 for exactly those cycles.
  - Beat 3 written once after release; no beat lost or duplicated.
REQ-043 in_empty high for 10 cycles before the second macroblock:
  - in_rd and eng_start delayed until in_empty falls.
  - perf_in_stall=10 with WEBP_MB_SEQ_PERF_EN.
REQ-044 Boundary update with bnd_init=all 0x7F and bnd_next=0xA5 pattern:
  - bnd_q=0x7F pattern during the first eng_start.
  - bnd_q=0xA5 pattern at the second eng_start.
REQ-045 abort asserted mid-DRAIN of the first macroblock:
  - State returns to IDLE; no further out_wr; done never pulses.
  - A following start restarts at x=0, y=0 with bnd_init.
REQ-046 w1=0, h1=0:
  - Single macroblock, 7 writes.
  - done pulses one cycle after the last write.
  - Spurious eng_done during WAIT_IN is ignored.

Source files
------------

// File: rtl/webp_mb_sequencer_pkg.sv
// Shared types and default sizes for the WebP macroblock sequencer.
package webp_mb_sequencer_pkg;

    localparam int DEF_DATA_W    = 1024;
    localparam int DEF_NUM_BEATS = 7;
    localparam int DEF_BND_W     = 568;
    localparam int BEAT_CNT_W    = 4;    // covers NUM_BEATS up to 15

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_IN,
        ST_START,
        ST_BUSY,
        ST_DRAIN,
        ST_ADVANCE,
        ST_DONE
    } mb_state_t;

endpackage

// File: rtl/webp_mb_sequencer_serializer.sv
// Result buffer and beat counter: captures one engine result and streams it
// to the output FIFO one beat per non-full cycle.
module webp_beat_serializer
    import webp_mb_sequencer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_BEATS = DEF_NUM_BEATS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_load,
    input  logic [NUM_BEATS*DATA_W-1:0]   i_result,
    input  logic                          i_drain,
    input  logic                          i_out_full,
    output logic                          o_out_wr,
    output logic [DATA_W-1:0]             o_out_data,
    output logic                          o_last_wr
);

    logic [NUM_BEATS*DATA_W-1:0] r_buf;
    logic [BEAT_CNT_W-1:0]       r_beat;

    assign o_out_wr   = i_drain & ~i_out_full;
    assign o_last_wr  = o_out_wr && (r_beat == BEAT_CNT_W'(NUM_BEATS - 1));
    // The counter only moves on a write, so the selected beat holds while full.
    assign o_out_data = r_buf[r_beat*DATA_W +: DATA_W];

    // NOTE: the buffer is reset like any other register so out_data reads 0
    // during and straight after reset; it is flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_beat <= '0;
        end else if (i_load) begin
            r_buf  <= i_result;
            r_beat <= '0;
        end else if (o_out_wr) begin
            r_beat <= o_last_wr ? '0 : r_beat + BEAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/webp_mb_sequencer.sv
// Macroblock sequencer: walks a frame of macroblocks through input pop, engine
// run and result drain. Define WEBP_MB_SEQ_PERF_EN to add stall/busy counters.
module webp_mb_sequencer
    import webp_mb_sequencer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_BEATS = DEF_NUM_BEATS,
    parameter int COORD_W   = 10,
    parameter int BND_W     = DEF_BND_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [COORD_W-1:0]           i_w1,
    input  logic [COORD_W-1:0]           i_h1,
    input  logic [BND_W-1:0]             i_bnd_init,
    input  logic                         i_in_empty,
    output logic                         o_in_rd,
    output logic                         o_eng_start,
    input  logic                         i_eng_done,
    input  logic [NUM_BEATS*DATA_W-1:0]  i_eng_result,
    input  logic [BND_W-1:0]             i_bnd_next,
    output logic [COORD_W-1:0]           o_x,
    output logic [COORD_W-1:0]           o_y,
    output logic [BND_W-1:0]             o_bnd_q,
    input  logic                         i_out_full,
    output logic                         o_out_wr,
    output logic [DATA_W-1:0]            o_out_data,
`ifdef WEBP_MB_SEQ_PERF_EN
    output logic [31:0]                  o_perf_in_stall,
    output logic [31:0]                  o_perf_out_stall,
    output logic [31:0]                  o_perf_eng_busy,
`endif
    output logic                         o_busy,
    output logic                         o_done
);

    mb_state_t            r_state;
    mb_state_t            w_state_next;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic [BND_W-1:0]     r_bnd_q;
    logic [BND_W-1:0]     r_bnd_shadow;
    logic                 w_load;
    logic                 w_drain;
    logic                 w_last_wr;
    logic                 w_last_col;
    logic                 w_frame_end;

    assign w_last_col  = (r_x == i_w1);
    assign w_frame_end = w_last_col && (r_y == i_h1);
    assign w_load      = (r_state == ST_BUSY) && i_eng_done && !i_abort;
    assign w_drain     = (r_state == ST_DRAIN) && !i_abort;

    assign o_in_rd     = (r_state == ST_WAIT_IN) && !i_in_empty && !i_abort;
    assign o_eng_start = (r_state == ST_START) && !i_abort;
    assign o_done      = (r_state == ST_DONE) && !i_abort;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_bnd_q     = r_bnd_q;

    webp_beat_serializer #(
        .DATA_W    (DATA_W),
        .NUM_BEATS (NUM_BEATS)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_result   (i_eng_result),
        .i_drain    (w_drain),
        .i_out_full (i_out_full),
        .o_out_wr   (o_out_wr),
        .o_out_data (o_out_data),
        .o_last_wr  (w_last_wr)
    );

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (i_start) w_state_next = ST_INIT;
            ST_INIT:    w_state_next = ST_WAIT_IN;
            ST_WAIT_IN: if (!i_in_empty) w_state_next = ST_START;
            ST_START:   w_state_next = ST_BUSY;
            ST_BUSY:    if (i_eng_done) w_state_next = ST_DRAIN;
            ST_DRAIN:   if (w_last_wr) w_state_next = w_frame_end ? ST_DONE : ST_ADVANCE;
            ST_ADVANCE: w_state_next = ST_WAIT_IN;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (i_abort) w_state_next = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_bnd_q      <= '0;
            r_bnd_shadow <= '0;
        end else begin
            r_state <= w_state_next;
            // Abort freezes coordinates and boundary context where they are.
            if (!i_abort) begin
                if (r_state == ST_INIT) begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_bnd_q <= i_bnd_init;
                end
                if (w_load) r_bnd_shadow <= i_bnd_next;
                if (r_state == ST_ADVANCE) begin
                    r_bnd_q <= r_bnd_shadow;
                    if (w_last_col) begin
                        r_x <= '0;
                        r_y <= r_y + COORD_W'(1);
                    end else begin
                        r_x <= r_x + COORD_W'(1);
                    end
                end
            end
        end
    end

`ifdef WEBP_MB_SEQ_PERF_EN
    logic [31:0] r_perf_in_stall;
    logic [31:0] r_perf_out_stall;
    logic [31:0] r_perf_eng_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_in_stall  <= '0;
            r_perf_out_stall <= '0;
            r_perf_eng_busy  <= '0;
        end else if (r_state == ST_INIT) begin
            r_perf_in_stall  <= '0;
            r_perf_out_stall <= '0;
            r_perf_eng_busy  <= '0;
        end else begin
            if (r_state == ST_WAIT_IN && i_in_empty && r_perf_in_stall != '1)
                r_perf_in_stall <= r_perf_in_stall + 32'd1;
            if (r_state == ST_DRAIN && i_out_full && r_perf_out_stall != '1)
                r_perf_out_stall <= r_perf_out_stall + 32'd1;
            if (r_state == ST_BUSY && r_perf_eng_busy != '1)
                r_perf_eng_busy <= r_perf_eng_busy + 32'd1;
        end
    end

    assign o_perf_in_stall  = r_perf_in_stall;
    assign o_perf_out_stall = r_perf_out_stall;
    assign o_perf_eng_busy  = r_perf_eng_busy;
`endif

endmodule

// File: tb/tb_webp_mb_sequencer.sv
// Directed bench for webp_mb_sequencer: environment models FIFOs and engine,
// main thread runs frames and checks hand-computed counts, order and timing.
module tb_webp_mb_sequencer;

    localparam int DATA_W    = 32;
    localparam int NUM_BEATS = 7;
    localparam int COORD_W   = 10;
    localparam int BND_W     = 568;
    localparam int ENG_LAT   = 20;
    localparam logic [BND_W-1:0] BND_7F = {71{8'h7F}};
    localparam logic [BND_W-1:0] BND_A5 = {71{8'hA5}};
    localparam logic [BND_W-1:0] BND_3C = {71{8'h3C}};

    logic                         clk;
    logic                         rst_n;
    logic                         start;
    logic                         abort;
    logic [COORD_W-1:0]           w1;
    logic [COORD_W-1:0]           h1;
    logic [BND_W-1:0]             bnd_init;
    logic                         in_empty;
    logic                         in_rd;
    logic                         eng_start;
    logic                         eng_done;
    logic [NUM_BEATS*DATA_W-1:0]  eng_result;
    logic [BND_W-1:0]             bnd_next;
    logic [COORD_W-1:0]           x;
    logic [COORD_W-1:0]           y;
    logic [BND_W-1:0]             bnd_q;
    logic                         out_full;
    logic                         out_wr;
    logic [DATA_W-1:0]            out_data;
    logic                         busy;
    logic                         done;
`ifdef WEBP_MB_SEQ_PERF_EN
    logic [31:0]                  perf_in_stall;
    logic [31:0]                  perf_out_stall;
    logic [31:0]                  perf_eng_busy;
`endif

    webp_mb_sequencer #(
        .DATA_W    (DATA_W),
        .NUM_BEATS (NUM_BEATS),
        .COORD_W   (COORD_W),
        .BND_W     (BND_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_abort          (abort),
        .i_w1             (w1),
        .i_h1             (h1),
        .i_bnd_init       (bnd_init),
        .i_in_empty       (in_empty),
        .o_in_rd          (in_rd),
        .o_eng_start      (eng_start),
        .i_eng_done       (eng_done),
        .i_eng_result     (eng_result),
        .i_bnd_next       (bnd_next),
        .o_x              (x),
        .o_y              (y),
        .o_bnd_q          (bnd_q),
        .i_out_full       (out_full),
        .o_out_wr         (out_wr),
        .o_out_data       (out_data),
`ifdef WEBP_MB_SEQ_PERF_EN
        .o_perf_in_stall  (perf_in_stall),
        .o_perf_out_stall (perf_out_stall),
        .o_perf_eng_busy  (perf_eng_busy),
`endif
        .o_busy           (busy),
        .o_done           (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result beat k for macroblock (bx,by) as the engine model produces it.
    function automatic logic [DATA_W-1:0] beat_val(input logic [3:0] bx, input logic [3:0] by,
                                                   input int k);
        return {8'hC0, bx, by, 8'h00, 8'(k)};
    endfunction

    // Environment state: written only by the env process, read by main.
    int                 mode;         // 0 plain, 1 out_full, 2 in_empty, 3 abort, 4 spurious done
    int                 cyc;
    int                 eng_cnt, full_left, empty_left;
    bit                 trig, started, prev_full;
    logic [DATA_W-1:0]  prev_data;
    int                 f_rd, f_eng, f_wr, f_done;
    int                 t_start, t_done, t_last_wr, t_wr7, t_rd1, t_rd2;
    int                 full_cyc, wr_while_full, hold_bad;
    logic [DATA_W-1:0]  wr_q[$];
    logic [7:0]         xy_q[$];
    logic [BND_W-1:0]   bnd_log[$];

    assign bnd_next = BND_A5;

    initial begin : env
        in_empty = 1'b0; out_full = 1'b0; abort = 1'b0; eng_done = 1'b0; eng_result = '0;
        cyc = 0; eng_cnt = 0; full_left = 0; empty_left = 0; trig = 1'b0; started = 1'b0;
        prev_full = 1'b0; prev_data = '0;
        f_rd = 0; f_eng = 0; f_wr = 0; f_done = 0;
        t_start = 0; t_done = 0; t_last_wr = 0; t_wr7 = 0; t_rd1 = 0; t_rd2 = 0;
        full_cyc = 0; wr_while_full = 0; hold_bad = 0;
        forever begin
            @(negedge clk);
            cyc++;
            eng_done = 1'b0;
            abort    = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0; full_left = 0; empty_left = 0; out_full = 1'b0; in_empty = 1'b0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_done = 1'b1;
                        for (int k = 0; k < NUM_BEATS; k++)
                            eng_result[k*DATA_W +: DATA_W] = beat_val(x[3:0], y[3:0], k);
                    end
                end
                if (mode == 4 && started && cyc == t_start + 4) begin
                    eng_done   = 1'b1;
                    eng_result = '1;
                end
                if (mode == 1 && !trig && f_wr == 3) begin trig = 1'b1; full_left = 5; end
                if (mode == 2 && !trig && f_wr == 7) begin trig = 1'b1; empty_left = 11; end
                if (mode == 4 && !trig && started && cyc == t_start + 1) begin
                    trig = 1'b1; empty_left = 6;
                end
                if (mode == 3 && !trig && f_wr == 3) begin trig = 1'b1; abort = 1'b1; end
                out_full = (full_left != 0);
                if (full_left > 0) full_left--;
                in_empty = (empty_left != 0);
                if (empty_left > 0) empty_left--;
            end
            #1;
            if (start) begin
                started = 1'b1; trig = 1'b0; t_start = cyc;
                f_rd = 0; f_eng = 0; f_wr = 0; f_done = 0;
                full_cyc = 0; wr_while_full = 0; hold_bad = 0;
                wr_q.delete(); xy_q.delete(); bnd_log.delete();
            end
            if (in_rd) begin
                f_rd++;
                if (f_rd == 1) t_rd1 = cyc;
                if (f_rd == 2) t_rd2 = cyc;
            end
            if (eng_start) begin
                f_eng++;
                xy_q.push_back({x[3:0], y[3:0]});
                bnd_log.push_back(bnd_q);
                eng_cnt = ENG_LAT;
            end
            if (out_full) begin
                full_cyc++;
                if (out_wr) wr_while_full++;
                if (prev_full && out_data !== prev_data) hold_bad++;
            end
            prev_full = out_full;
            prev_data = out_data;
            if (out_wr) begin
                f_wr++;
                wr_q.push_back(out_data);
                t_last_wr = cyc;
                if (f_wr == 7) t_wr7 = cyc;
            end
            if (done) begin
                f_done++;
                t_done = cyc;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] wr_at(input int idx);
        return (idx < wr_q.size()) ? wr_q[idx] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [7:0] xy_at(input int idx);
        return (idx < xy_q.size()) ? xy_q[idx] : 8'hEE;
    endfunction

    function automatic logic [BND_W-1:0] bnd_at(input int idx);
        return (idx < bnd_log.size()) ? bnd_log[idx] : '1;
    endfunction

    task automatic run_frame(input logic [COORD_W-1:0] w, input logic [COORD_W-1:0] h,
                             input logic [BND_W-1:0] b, input int m, input string tag);
        bit ok;
        @(negedge clk);
        mode = m; w1 = w; h1 = h; bnd_init = b;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        check({tag, "_idle_timeout"}, ok, 1);
        repeat (3) @(negedge clk);
    endtask

    // Checks every beat of macroblock m (m-th in write order) at coordinates (bx,by).
    task automatic check_mb_data(input string tag, input int m, input logic [3:0] bx,
                                 input logic [3:0] by);
        for (int k = 0; k < NUM_BEATS; k++)
            check($sformatf("%s_mb%0d_beat%0d", tag, m, k), wr_at(m*NUM_BEATS + k),
                  beat_val(bx, by, k));
    endtask

    initial begin : main
        logic [3:0] ex[4];
        logic [3:0] ey[4];
        ex = '{4'd0, 4'd1, 4'd0, 4'd1};
        ey = '{4'd0, 4'd0, 4'd1, 4'd1};
        mode = 0; start = 1'b0; w1 = '0; h1 = '0; bnd_init = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_rd", in_rd, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_out_wr", out_wr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_bnd_q", bnd_q, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2x2 frame, no stalls
        run_frame(1, 1, BND_7F, 0, "A");
        check("A_in_rd", f_rd, 4);
        check("A_eng_start", f_eng, 4);
        check("A_out_wr", f_wr, 28);
        check("A_done", f_done, 1);
        check("A_frame_cycles", t_done - t_start, 121);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("A_xy%0d", m), xy_at(m), {ex[m], ey[m]});
            check_mb_data("A", m, ex[m], ey[m]);
        end
        check("A_bnd_first", bnd_at(0), BND_7F);
        check("A_bnd_second", bnd_at(1), BND_A5);

        // Output FIFO full for 5 cycles during beat 3
        run_frame(0, 0, BND_7F, 1, "B");
        check("B_out_wr", f_wr, 7);
        check("B_full_cycles", full_cyc, 5);
        check("B_wr_while_full", wr_while_full, 0);
        check("B_data_hold", hold_bad, 0);
        check_mb_data("B", 0, 4'd0, 4'd0);
        check("B_done_after_last", t_done - t_last_wr, 1);
`ifdef WEBP_MB_SEQ_PERF_EN
        check("B_perf_out_stall", perf_out_stall, 5);
        check("B_perf_eng_busy", perf_eng_busy, 20);
`endif

        // Input FIFO empty for 10 WAIT_IN cycles before the second macroblock
        run_frame(1, 0, BND_7F, 2, "C");
        check("C_out_wr", f_wr, 14);
        check("C_eng_start", f_eng, 2);
        check("C_rd2_delay", t_rd2 - t_wr7, 12);
        check("C_xy1", xy_at(1), {4'd1, 4'd0});
        check_mb_data("C", 1, 4'd1, 4'd0);
`ifdef WEBP_MB_SEQ_PERF_EN
        check("C_perf_in_stall", perf_in_stall, 10);
`endif

        // Abort in the middle of the first drain
        run_frame(1, 1, BND_7F, 3, "D");
        repeat (30) @(negedge clk);
        check("D_out_wr", f_wr, 3);
        check("D_done", f_done, 0);
        check("D_eng_start", f_eng, 1);
        check("D_busy", busy, 0);
        check("D_x", x, 0);
        check("D_y", y, 0);
        check("D_bnd_q", bnd_q, BND_7F);

        // Restart after abort with a new boundary context
        run_frame(0, 0, BND_3C, 0, "E");
        check("E_xy0", xy_at(0), 8'h00);
        check("E_bnd_first", bnd_at(0), BND_3C);
        check("E_out_wr", f_wr, 7);
        check("E_done", f_done, 1);
        check_mb_data("E", 0, 4'd0, 4'd0);

        // Single macroblock with a spurious eng_done while waiting for input
        run_frame(0, 0, BND_7F, 4, "F");
        check("F_rd_delay", t_rd1 - t_start, 7);
        check("F_eng_start", f_eng, 1);
        check("F_out_wr", f_wr, 7);
        check("F_done", f_done, 1);
        check("F_frame_cycles", t_done - t_start, 36);
        check("F_done_after_last", t_done - t_last_wr, 1);
        check_mb_data("F", 0, 4'd0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
